// File: rtl/pwm_ctrl.sv
// pwm_ctrl: configuration sequencer for the 16-bit pwm counter/comparator.
// The host fills shadow registers over a valid/ready port and commits; the new
// top/comp/mode/pol set is applied at the next period boundary (counter == 0).
// comp may ramp toward its target by a fixed step per period, and a mode
// change pulses a one-cycle restart into the pwm.
module pwm_ctrl #(
  parameter logic [15:0] RESET_TOP  = 16'hFFFF,
  parameter logic [15:0] RESET_COMP = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [1:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        commit,
  input  logic [15:0] counter,
  output logic [15:0] top,
  output logic [15:0] comp,
  output logic        mode,
  output logic        pol,
  output logic        pwm_rst,
  output logic        busy,
  output logic        period_tick
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    RAMP    = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] sh_top;
  logic [15:0] sh_target;
  logic [15:0] sh_step;
  logic        sh_mode;
  logic        sh_pol;
  logic        pwm_rst_d;
  logic        boundary;
  logic [15:0] next_comp;

  // One step of comp toward tgt; differences are taken in 17 bits so the
  // comparison never wraps and the result clamps exactly on the target.
  function automatic logic [15:0] step_toward(input logic [15:0] cur,
                                              input logic [15:0] tgt,
                                              input logic [15:0] stp);
    logic [16:0] diff;
    logic [15:0] res;
    if (stp == 16'd0) begin
      res = tgt;
    end else if (tgt > cur) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      res  = (diff <= {1'b0, stp}) ? tgt : (cur + stp);
    end else begin
      diff = {1'b0, cur} - {1'b0, tgt};
      res  = (diff <= {1'b0, stp}) ? tgt : (cur - stp);
    end
    return res;
  endfunction

  // A period boundary is counter == 0 outside the two cycles where a
  // restart pulse holds the pwm counter at 0, so each period counts once.
  assign boundary = (counter == 16'd0) && !pwm_rst && !pwm_rst_d;

  // Candidate comp value for the next boundary.
  always_comb begin
    next_comp = step_toward(comp, sh_target, sh_step);
  end

  // Sequencer: shadow writes, commit handling and glitch-free apply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      top         <= RESET_TOP;
      comp        <= RESET_COMP;
      mode        <= 1'b0;
      pol         <= 1'b1;
      sh_top      <= RESET_TOP;
      sh_target   <= RESET_COMP;
      sh_step     <= 16'd0;
      sh_mode     <= 1'b0;
      sh_pol      <= 1'b1;
      pwm_rst     <= 1'b0;
      pwm_rst_d   <= 1'b0;
      busy        <= 1'b0;
      wr_ready    <= 1'b1;
      period_tick <= 1'b0;
    end else begin
      pwm_rst_d   <= pwm_rst;
      period_tick <= boundary;
      pwm_rst     <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_valid && wr_ready) begin
            case (wr_addr)
              2'd0:    sh_top    <= wr_data;
              2'd1:    sh_target <= wr_data;
              2'd2:    sh_step   <= wr_data;
              2'd3: begin
                sh_mode <= wr_data[1];
                sh_pol  <= wr_data[0];
              end
              default: sh_top    <= sh_top;
            endcase
          end
          if (commit) begin
            state    <= PENDING;
            busy     <= 1'b1;
            wr_ready <= 1'b0;
          end
        end
        PENDING: begin
          if (boundary) begin
            top  <= sh_top;
            mode <= sh_mode;
            pol  <= sh_pol;
            comp <= next_comp;
            if (sh_mode != mode) begin
              pwm_rst <= 1'b1;
            end
            if ((next_comp == sh_target) || (sh_step == 16'd0)) begin
              state    <= IDLE;
              busy     <= 1'b0;
              wr_ready <= 1'b1;
            end else begin
              state <= RAMP;
            end
          end
        end
        RAMP: begin
          if (boundary) begin
            comp <= next_comp;
            if (next_comp == sh_target) begin
              state    <= IDLE;
              busy     <= 1'b0;
              wr_ready <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          wr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ctrl.sv
// Directed self-checking bench for pwm_ctrl. The pwm counter is driven
// directly so every boundary is placed by hand.
module tb_pwm_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic        commit;
  logic [15:0] counter;
  logic [15:0] top;
  logic [15:0] comp;
  logic        mode;
  logic        pol;
  logic        pwm_rst;
  logic        busy;
  logic        period_tick;

  int n_checks = 0;
  int n_errors = 0;
  int tick_cnt = 0;

  pwm_ctrl #(.RESET_TOP(16'hFFFF), .RESET_COMP(16'h0000)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit), .counter(counter),
    .top(top), .comp(comp), .mode(mode), .pol(pol), .pwm_rst(pwm_rst),
    .busy(busy), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges; observe 1 time unit after each edge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (period_tick) tick_cnt++;
    end
  endtask

  task automatic host_write(input logic [1:0] a, input logic [15:0] d);
    check("wr_ready_idle", wr_ready, 1);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    cyc(1);
    wr_valid = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    cyc(1);
    commit = 1'b0;
  endtask

  // One-cycle boundary: counter is 0 for exactly one sampled edge.
  task automatic boundary_cycle();
    counter = 16'd0;
    cyc(1);
    counter = 16'd1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_top"},  top, 16'hFFFF);
    check({tag, "_comp"}, comp, 16'h0000);
    check({tag, "_mode"}, mode, 0);
    check({tag, "_pol"},  pol, 1);
    check({tag, "_prst"}, pwm_rst, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_tick"}, period_tick, 0);
    check({tag, "_rdy"},  wr_ready, 1);
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_addr = 2'd0; wr_data = 16'd0;
    commit = 1'b0; counter = 16'd5;
    cyc(2);
    check_reset_state("rst");
    rst = 1'b0;
    cyc(1);
    check_reset_state("rel");

    // Apply top=9 comp=4 with step 0 at the next boundary.
    host_write(2'd0, 16'd9);
    host_write(2'd1, 16'd4);
    host_write(2'd2, 16'd0);
    host_write(2'd3, 16'h0001);
    do_commit();
    check("c1_busy", busy, 1);
    check("c1_rdy", wr_ready, 0);
    cyc(3);
    check("c1_wait_busy", busy, 1);
    check("c1_wait_top", top, 16'hFFFF);
    boundary_cycle();
    check("c1_top", top, 16'd9);
    check("c1_comp", comp, 16'd4);
    check("c1_pol", pol, 1);
    check("c1_mode", mode, 0);
    check("c1_tick", period_tick, 1);
    check("c1_prst", pwm_rst, 0);
    check("c1_busy_done", busy, 0);
    cyc(1);
    check("c1_tick_once", period_tick, 0);

    // Bring comp to 0, then ramp up to 10 by 3 with top=19.
    host_write(2'd1, 16'd0);
    do_commit();
    boundary_cycle();
    check("c2_pre_comp", comp, 16'd0);
    cyc(1);
    host_write(2'd0, 16'd19);
    host_write(2'd1, 16'd10);
    host_write(2'd2, 16'd3);
    do_commit();
    tick_cnt = 0;
    cyc(2);
    boundary_cycle(); check("up_1", comp, 16'd3);  check("up_busy1", busy, 1);
    check("up_top", top, 16'd19);
    cyc(3);
    boundary_cycle(); check("up_2", comp, 16'd6);  check("up_busy2", busy, 1);
    cyc(3);
    boundary_cycle(); check("up_3", comp, 16'd9);  check("up_busy3", busy, 1);
    cyc(3);
    boundary_cycle(); check("up_4", comp, 16'd10); check("up_busy4", busy, 0);
    cyc(3);
    check("up_ticks", tick_cnt, 4);
    check("up_hold", comp, 16'd10);

    // Ramp down from 10 to 1 by 4: 6, 2, 1.
    host_write(2'd1, 16'd1);
    host_write(2'd2, 16'd4);
    do_commit();
    cyc(1);
    boundary_cycle(); check("dn_1", comp, 16'd6); check("dn_busy1", busy, 1);
    cyc(2);
    boundary_cycle(); check("dn_2", comp, 16'd2); check("dn_busy2", busy, 1);
    cyc(2);
    boundary_cycle(); check("dn_3", comp, 16'd1); check("dn_busy3", busy, 0);
    cyc(2);

    // Mode change 0 -> 1: restart pulse and a single tick.
    host_write(2'd3, 16'h0003);
    do_commit();
    cyc(1);
    counter = 16'd0;
    cyc(1);
    check("mc_mode", mode, 1);
    check("mc_prst", pwm_rst, 1);
    check("mc_tick", period_tick, 1);
    cyc(1);
    check("mc_prst_off", pwm_rst, 0);
    check("mc_tick_mask1", period_tick, 0);
    cyc(1);
    check("mc_tick_mask2", period_tick, 0);
    counter = 16'd1;
    cyc(1);
    check("mc_tick_mask3", period_tick, 0);
    check("mc_busy", busy, 0);

    // Commit with unchanged values: waits one boundary, no restart.
    do_commit();
    check("same_busy", busy, 1);
    cyc(2);
    boundary_cycle();
    check("same_prst", pwm_rst, 0);
    check("same_busy_done", busy, 0);
    check("same_comp", comp, 16'd1);

    // Write and commit in the same cycle; a write during busy is held.
    host_write(2'd2, 16'd0);
    wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 16'd7; commit = 1'b1;
    cyc(1);
    commit = 1'b0; wr_addr = 2'd0; wr_data = 16'd3;
    check("held_rdy", wr_ready, 0);
    cyc(2);
    check("held_rdy2", wr_ready, 0);
    boundary_cycle();
    check("wc_comp", comp, 16'd7);
    check("wc_top_unchanged", top, 16'd19);
    check("wc_rdy", wr_ready, 1);
    cyc(1);
    wr_valid = 1'b0;
    do_commit();
    boundary_cycle();
    check("held_top", top, 16'd3);

    // Reset in the middle of a ramp discards everything.
    host_write(2'd1, 16'd20);
    host_write(2'd2, 16'd2);
    do_commit();
    boundary_cycle();
    check("rr_comp", comp, 16'd9);
    check("rr_busy", busy, 1);
    cyc(1);
    rst = 1'b1;
    #1;
    check("rr_async_comp", comp, 16'd0);
    cyc(1);
    rst = 1'b0;
    cyc(1);
    check_reset_state("rr");
    do_commit();
    boundary_cycle();
    check("rr_sh_top", top, 16'hFFFF);
    check("rr_sh_comp", comp, 16'd0);
    check("rr_sh_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pwm_ctrl.md
# pwm_ctrl

Configuration sequencer for the 16-bit `pwm` counter/comparator. A host writes shadow registers over a valid/ready port and issues a commit. The block then applies the new top/comp/mode/pol glitch-free at the next period boundary, which it detects from the pwm `counter` output. It optionally ramps comp toward its target by a fixed step per period, and pulses a restart into the pwm when the counting mode changes.

## Interface

- RESET_TOP, 16'hFFFF, top value after reset
- RESET_COMP, 16'h0000, comp value after reset

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wr_valid  in  1  host write request
- wr_ready  out  1  write accepted when wr_valid & wr_ready
- wr_addr  in  2  0 = top, 1 = comp target, 2 = ramp step, 3 = ctrl {bit1 mode, bit0 pol}
- wr_data  in  16  write data
- commit  in  1  one-cycle request to apply shadow registers
- counter  in  16  pwm counter value
- top  out  16  to pwm top
- comp  out  16  to pwm comp
- mode  out  1  to pwm mode
- pol  out  1  to pwm pol
- pwm_rst  out  1  one-cycle restart pulse, OR'd into the pwm reset
- busy  out  1  commit in progress
- period_tick  out  1  one-cycle pulse per qualified boundary

## Operation

- Shadow registers: sh_top, sh_target, sh_step, sh_mode, sh_pol.
- Active registers: top, comp, mode, pol. All outputs are registered.
- Boundary condition: `counter == 0 && !pwm_rst && !pwm_rst_d`, where pwm_rst_d is pwm_rst delayed by one cycle. There is exactly one boundary per period in both pwm modes.
- FSM states: IDLE, PENDING, RAMP.
  - IDLE: wr_ready = 1. An accepted write updates the addressed shadow register at the clock edge. commit -> PENDING.
  - PENDING: wr_ready = 0; commit is ignored. On boundary:
    - top <= sh_top, mode <= sh_mode, pol <= sh_pol.
    - comp takes one step toward sh_target.
    - If sh_mode != mode: pwm_rst <= 1 for one cycle.
    - If comp reaches sh_target, or sh_step == 0 -> IDLE; otherwise -> RAMP.
  - RAMP: wr_ready = 0; commit is ignored. On each boundary comp steps again; when comp == sh_target -> IDLE.
- Step arithmetic (17-bit, no wrap):
  - If sh_step == 0: comp <= sh_target.
  - Else if sh_target > comp: comp <= (sh_target - comp <= sh_step) ? sh_target : comp + sh_step.
  - Else (going down): comp <= (comp - sh_target <= sh_step) ? sh_target : comp - sh_step.
- busy = (state != IDLE).
- A commit whose shadow values equal the active values still waits for one boundary, then returns to IDLE. No pwm_rst is issued.
- wr_valid and commit in the same IDLE cycle: the write lands in shadow and the commit is taken. The applied set includes that write.

## Timing

- Reset values: top = RESET_TOP, comp = RESET_COMP, mode = 0, pol = 1. Shadow registers equal the active values, and sh_step = 0. pwm_rst = 0, busy = 0, period_tick = 0, state IDLE, wr_ready = 1 after reset release.
- Commit to busy: commit sampled at edge n -> busy = 1 from cycle n+1.
- Boundary to outputs: boundary sampled at edge b -> top/comp/mode/pol change at edge b, visible in cycle b+1. period_tick is high in cycle b+1. The pwm counter is 1 in that cycle, so the whole new period uses the new values.
- Mode change: pwm_rst is high during cycle b+1 only. The pwm counter stays 0 through cycle b+2. The boundary mask prevents a double tick and a double ramp step.
- Ramp rate: comp steps once per period. Worst-case settling is ceil(|target - comp| / step) periods.
- top = 0 in sawtooth mode: counter is constantly 0, so every cycle is a boundary. Ramps advance once per cycle; this is legal.
- rst asserted mid-PENDING or mid-RAMP: immediate return to reset values; the pending commit is discarded.
- wr_ready de-asserts in the cycle after the commit edge. A write presented in that cycle is held off until IDLE.

## Test plan

- Write top=9, target=4, step=0, ctrl=2'b01, then commit, with the pwm free-running at top=0xFFFF. -> busy stays high until counter==0. top=9 and comp=4 appear in the next cycle, period_tick pulses, no pwm_rst; out is high for counter 0..3.
- comp=0, target=10, step=3, top=19. -> comp goes 3, 6, 9, 10 on four consecutive boundaries. busy clears with the step to 10; exactly four period_tick pulses.
- comp=10, target=1, step=4. -> comp goes 6, 2, 1; no underflow below 1.
- Commit with sh_mode 0 -> 1. -> one-cycle pwm_rst one cycle after the boundary. counter holds 0 for two cycles with period_tick pulsing only once, then counting up/down restarts.
- wr_valid + commit in the same cycle with wr_addr=1, data=7. -> the applied comp is 7. Writes during busy see wr_ready=0 and are held.
- rst pulse while in RAMP (comp mid-ramp). -> all outputs return to reset values; busy=0, wr_ready=1 in the first cycle after release.
